scoreboard_register_file: RTL and testbench
===========================================

Name: scoreboard_register_file

Overview:
- Parametrised successor to the 16x16 register file.
- Configurable width and depth, two registered read ports, one write-back port, and an optional hardwired-zero register 0.
- A per-register busy scoreboard with valid/ready handshakes stalls fetch on RAW and WAW hazards.
- Sits between instruction decode (fetch side) and the execute stage (operand side); the write-back stage drives the write port.

Parameters:
- DATA_WIDTH, 16, width of each register and of all data ports.
- REG_COUNT, 16, number of architectural registers; must be at least 2.
- ADDR_WIDTH, $clog2(REG_COUNT), register address width.
- ZERO_REG, 0, when 1 register 0 always reads 0, ignores writes and is never busy.

Ports:
- clk  in  1  system clock, all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- fetch_valid  in  1  decode presents an operand request.
- fetch_ready  out  1  request accepted this cycle when high together with fetch_valid.
- rs1_addr  in  ADDR_WIDTH  source register A.
- rs2_addr  in  ADDR_WIDTH  source register B.
- rd_addr  in  ADDR_WIDTH  destination register.
- rd_claim  in  1  request will write rd; marks rd busy on accept.
- op_valid  out  1  operand pair valid.
- op_ready  in  1  execute consumes the operands.
- op_a  out  DATA_WIDTH  value of rs1.
- op_b  out  DATA_WIDTH  value of rs2.
- wb_en  in  1  write-back strobe.
- wb_addr  in  ADDR_WIDTH  write-back register.
- wb_data  in  DATA_WIDTH  write-back value.
- busy  out  REG_COUNT  scoreboard, bit i set means register i has a pending write.
- err_wb_unclaimed  out  1  sticky error: write-back to a register that was not busy.

Behaviour:
- Reset (async, rst_n low):
  - All registers and busy go to 0.
  - op_valid, op_a, op_b and err_wb_unclaimed go to 0.
  - fetch_ready is combinational, so it follows the reset state.
  - Reset mid-handshake discards any in-flight operand pair and all pending claims.
- Write port: when wb_en is high, the register at wb_addr takes wb_data at the clock edge. With ZERO_REG=1 and wb_addr=0 the write is discarded.
- Effective busy: eff_busy[i] = busy[i] & ~(wb_en & wb_addr==i). A same-cycle write-back resolves the hazard.
- Hazard = eff_busy[rs1] | eff_busy[rs2] | (rd_claim & eff_busy[rd]).
  - Register 0 never contributes when ZERO_REG=1.
  - Addresses at or above REG_COUNT never cause a hazard and read 0.
- fetch_ready = (~op_valid | op_ready) & ~hazard. It is combinational and does not depend on fetch_valid.
- Accept occurs when fetch_valid & fetch_ready. On accept, at the next edge:
  - op_valid goes to 1.
  - op_a and op_b are captured. Each source takes wb_data if wb_en and wb_addr match that source (bypass); otherwise it takes the stored value.
  - Latency is 1 cycle from accept to op_valid.
- Operand hold:
  - While op_valid & ~op_ready, op_a and op_b stay stable.
  - op_valid clears on op_ready only if no new accept occurs in the same cycle.
  - Back-to-back accepts give one request per cycle.
- Busy update, per bit, each edge:
  - Set if accept & rd_claim & rd_addr==i.
  - Otherwise clear if wb_en & wb_addr==i.
  - If set and clear hit the same bit in the same cycle, set wins: the new claim supersedes the completed write.
- err_wb_unclaimed sets when wb_en & ~busy[wb_addr], excluding register 0 with ZERO_REG=1. It clears only on reset.
- A write-back to a register that is not busy still updates the register.
- ZERO_REG=1: busy[0] is always 0, op_a or op_b reads 0 for address 0, and rd_claim to register 0 is ignored.
- No flow-control dependence on wb_en: the write port is always accepted.

Decomposition:
- Shared package scoreboard_pkg holds:
  - the default DATA_WIDTH and REG_COUNT localparams;
  - the typedefs reg_addr_t and reg_data_t;
  - the function hazard_check(busy, addr).
- One sub-module, scoreboard_bits: the busy vector, set/clear priority and the err flag.
- The data array and operand stage stay in the top module.

Test Plan:
- Reset then read: pulse rst_n low, then fetch rs1=3, rs2=5 -> op_valid one cycle later, op_a=0, op_b=0, busy=0.
- Write and read: wb r3=0x1234, next cycle fetch rs1=3 -> op_a=0x1234 one cycle after accept.
- RAW stall and bypass:
  - Fetch rd=4 with rd_claim; then fetch rs1=4 -> fetch_ready=0 for 3 cycles, busy[4]=1.
  - Then wb r4=0xBEEF and the fetch in the same cycle -> accepted, op_a=0xBEEF, busy[4]=0.
- Back-pressure: op_ready=0 for 4 cycles after an accept -> op_a and op_b stable, fetch_ready=0. op_ready=1 with a new request -> next pair one cycle later with no bubble.
- Set-wins race: busy[7]=1; same cycle wb r7 and accept with rd=7 claim -> busy[7] stays 1 and the register holds the wb value.
- Zero register and error:
  - ZERO_REG=1: wb r0=0xFFFF, then fetch rs1=0 -> op_a=0, err_wb_unclaimed=0.
  - wb r9 while busy[9]=0 -> err_wb_unclaimed=1 until reset.

Source files
------------

// File: rtl/scoreboard_pkg.sv
// Shared types and helpers for the scoreboarded register file.
// Busy vectors are widened to a fixed maximum so one hazard helper fits any depth.
package scoreboard_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_REG_COUNT  = 16;
  localparam int MAX_REG_COUNT  = 1024;

  typedef logic [DEF_DATA_WIDTH-1:0]         reg_data_t;
  typedef logic [$clog2(DEF_REG_COUNT)-1:0]  reg_addr_t;
  typedef logic [MAX_REG_COUNT-1:0]          busy_vec_t;
  typedef logic [$clog2(MAX_REG_COUNT)-1:0]  busy_idx_t;

  function automatic logic hazard_check(
    input busy_vec_t busy,
    input busy_idx_t addr
  );
    return busy[addr];
  endfunction

endpackage

// File: rtl/scoreboard_bits.sv
// Per-register busy scoreboard with set-over-clear priority
// and a sticky flag for write-backs that hit an idle register.
module scoreboard_bits
  import scoreboard_pkg::*;
#(
  parameter int REG_COUNT  = DEF_REG_COUNT,
  parameter int ADDR_WIDTH = $clog2(REG_COUNT),
  parameter int ZERO_REG   = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  set_en,
  input  logic [ADDR_WIDTH-1:0] set_addr,
  input  logic                  wb_en,
  input  logic [ADDR_WIDTH-1:0] wb_addr,
  output logic [REG_COUNT-1:0]  busy,
  output logic                  err
);

  logic [REG_COUNT-1:0] set_dec;
  logic [REG_COUNT-1:0] clr_dec;
  logic [REG_COUNT-1:0] busy_nxt;
  logic                 wb_zero;
  logic                 unclaimed;

  always_comb begin
    set_dec = '0;
    clr_dec = '0;
    for (int i = 0; i < REG_COUNT; i++) begin
      clr_dec[i] = wb_en && (wb_addr == ADDR_WIDTH'(i));
      if (!(ZERO_REG != 0 && i == 0)) begin
        set_dec[i] = set_en && (set_addr == ADDR_WIDTH'(i));
      end
    end
  end

  // A new claim supersedes a write-back completing on the same edge
  assign busy_nxt  = set_dec | (busy & ~clr_dec);
  assign wb_zero   = (ZERO_REG != 0) && (wb_addr == '0);
  assign unclaimed = wb_en && !(|(clr_dec & busy)) && !wb_zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
      err  <= 1'b0;
    end else begin
      busy <= busy_nxt;
      if (unclaimed) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/scoreboard_register_file.sv
// Register file with two registered read ports, one write-back port
// and a busy scoreboard that stalls fetch on RAW/WAW hazards.
module scoreboard_register_file
  import scoreboard_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int REG_COUNT  = DEF_REG_COUNT,
  parameter int ADDR_WIDTH = $clog2(REG_COUNT),
  parameter int ZERO_REG   = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fetch_valid,
  output logic                  fetch_ready,
  input  logic [ADDR_WIDTH-1:0] rs1_addr,
  input  logic [ADDR_WIDTH-1:0] rs2_addr,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic                  rd_claim,
  output logic                  op_valid,
  input  logic                  op_ready,
  output logic [DATA_WIDTH-1:0] op_a,
  output logic [DATA_WIDTH-1:0] op_b,
  input  logic                  wb_en,
  input  logic [ADDR_WIDTH-1:0] wb_addr,
  input  logic [DATA_WIDTH-1:0] wb_data,
  output logic [REG_COUNT-1:0]  busy,
  output logic                  err_wb_unclaimed
);

  logic [DATA_WIDTH-1:0] rf [REG_COUNT];
  logic [REG_COUNT-1:0]  wb_dec;
  logic [REG_COUNT-1:0]  eff_busy;
  busy_vec_t             eff_wide;
  logic                  hazard;
  logic                  accept;
  logic [DATA_WIDTH-1:0] a_nxt;
  logic [DATA_WIDTH-1:0] b_nxt;

  always_comb begin
    wb_dec = '0;
    for (int i = 0; i < REG_COUNT; i++) begin
      wb_dec[i] = wb_en && (wb_addr == ADDR_WIDTH'(i));
    end
  end

  // Same-cycle write-back already resolves the hazard
  assign eff_busy = busy & ~wb_dec;
  assign eff_wide = busy_vec_t'(eff_busy);

  assign hazard =
    hazard_check(eff_wide, busy_idx_t'(rs1_addr)) |
    hazard_check(eff_wide, busy_idx_t'(rs2_addr)) |
    (rd_claim & hazard_check(eff_wide, busy_idx_t'(rd_addr)));

  assign fetch_ready = (~op_valid | op_ready) & ~hazard;
  assign accept      = fetch_valid & fetch_ready;

  // Out-of-range and hardwired-zero sources fall through to 0
  always_comb begin
    a_nxt = '0;
    b_nxt = '0;
    for (int i = 0; i < REG_COUNT; i++) begin
      if (!(ZERO_REG != 0 && i == 0)) begin
        if (rs1_addr == ADDR_WIDTH'(i)) begin
          a_nxt = wb_dec[i] ? wb_data : rf[i];
        end
        if (rs2_addr == ADDR_WIDTH'(i)) begin
          b_nxt = wb_dec[i] ? wb_data : rf[i];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        rf[i] <= '0;
      end
    end else begin
      for (int i = 0; i < REG_COUNT; i++) begin
        if (wb_dec[i] && !(ZERO_REG != 0 && i == 0)) begin
          rf[i] <= wb_data;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_valid <= 1'b0;
      op_a     <= '0;
      op_b     <= '0;
    end else if (accept) begin
      op_valid <= 1'b1;
      op_a     <= a_nxt;
      op_b     <= b_nxt;
    end else if (op_ready) begin
      op_valid <= 1'b0;
    end
  end

  scoreboard_bits #(
    .REG_COUNT  (REG_COUNT),
    .ADDR_WIDTH (ADDR_WIDTH),
    .ZERO_REG   (ZERO_REG)
  ) u_bits (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_en   (accept & rd_claim),
    .set_addr (rd_addr),
    .wb_en    (wb_en),
    .wb_addr  (wb_addr),
    .busy     (busy),
    .err      (err_wb_unclaimed)
  );

endmodule

// File: tb/tb_scoreboard_register_file.sv
// Self-checking bench: a reference model pushes expected operand
// pairs on accept and pops/compares them when execute consumes.
module tb_scoreboard_register_file;
  import scoreboard_pkg::*;

  logic      clk = 1'b0;
  logic      rst_n = 1'b0;
  logic      fetch_valid = 1'b0;
  logic      fetch_ready;
  reg_addr_t rs1_addr = '0;
  reg_addr_t rs2_addr = '0;
  reg_addr_t rd_addr = '0;
  logic      rd_claim = 1'b0;
  logic      op_valid;
  logic      op_ready = 1'b0;
  reg_data_t op_a;
  reg_data_t op_b;
  logic      wb_en = 1'b0;
  reg_addr_t wb_addr = '0;
  reg_data_t wb_data = '0;
  logic [15:0] busy;
  logic      err_wb_unclaimed;

  always #5 clk = ~clk;

  scoreboard_register_file #(
    .DATA_WIDTH (16),
    .REG_COUNT  (16),
    .ZERO_REG   (1)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .fetch_valid      (fetch_valid),
    .fetch_ready      (fetch_ready),
    .rs1_addr         (rs1_addr),
    .rs2_addr         (rs2_addr),
    .rd_addr          (rd_addr),
    .rd_claim         (rd_claim),
    .op_valid         (op_valid),
    .op_ready         (op_ready),
    .op_a             (op_a),
    .op_b             (op_b),
    .wb_en            (wb_en),
    .wb_addr          (wb_addr),
    .wb_data          (wb_data),
    .busy             (busy),
    .err_wb_unclaimed (err_wb_unclaimed)
  );

  typedef struct packed {
    reg_data_t a;
    reg_data_t b;
  } pair_t;

  pair_t       q[$];
  logic [15:0] mbusy;
  reg_data_t   mregs [16];
  logic        mopv;
  logic        merr;
  int          n_chk;
  int          n_pass;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic reg_data_t mval(input reg_addr_t a);
    if (a == 0) return '0;
    if (wb_en && wb_addr == a) return wb_data;
    return mregs[a];
  endfunction

  task automatic model_clear();
    mbusy = '0;
    mopv  = 1'b0;
    merr  = 1'b0;
    for (int i = 0; i < 16; i++) mregs[i] = '0;
    q.delete();
  endtask

  // Called #1 after a rising edge; returns #1 after the next one
  task automatic step(input logic fv, input reg_addr_t r1,
                      input reg_addr_t r2, input reg_addr_t rd,
                      input logic cl, input logic ordy,
                      input logic we, input reg_addr_t wa,
                      input reg_data_t wd);
    logic [15:0] eff;
    logic        haz;
    logic        exp_rdy;
    logic        acc;
    pair_t       p;
    fetch_valid = fv;
    rs1_addr    = r1;
    rs2_addr    = r2;
    rd_addr     = rd;
    rd_claim    = cl;
    op_ready    = ordy;
    wb_en       = we;
    wb_addr     = wa;
    wb_data     = wd;
    #1;
    chk("busy", busy, mbusy);
    chk("err", err_wb_unclaimed, merr);
    chk("op_valid", op_valid, mopv);
    if (mopv && q.size() > 0) begin
      chk("op_a", op_a, q[0].a);
      chk("op_b", op_b, q[0].b);
    end
    eff = mbusy;
    if (we) eff[wa] = 1'b0;
    haz = eff[r1] | eff[r2] | (cl & eff[rd]);
    exp_rdy = (!mopv || ordy) && !haz;
    chk("fetch_ready", fetch_ready, exp_rdy);
    acc = fv && exp_rdy;
    if (mopv && ordy && q.size() > 0) void'(q.pop_front());
    if (acc) begin
      p.a = mval(r1);
      p.b = mval(r2);
      q.push_back(p);
    end
    if (we && !mbusy[wa] && wa != 0) merr = 1'b1;
    if (we) begin
      mbusy[wa] = 1'b0;
      if (wa != 0) mregs[wa] = wd;
    end
    if (acc && cl && rd != 0) mbusy[rd] = 1'b1;
    mopv = acc || (mopv && !ordy);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 0, 0, 0, 1'b0, 1'b1, 1'b0, 0, 16'h0);
  endtask

  task automatic hard_reset();
    rst_n       = 1'b0;
    fetch_valid = 1'b0;
    rd_claim    = 1'b0;
    op_ready    = 1'b0;
    wb_en       = 1'b0;
    #1;
    chk("rst_op_valid", op_valid, 1'b0);
    chk("rst_busy", busy, 16'h0);
    chk("rst_err", err_wb_unclaimed, 1'b0);
    chk("rst_op_a", op_a, 16'h0);
    chk("rst_op_b", op_b, 16'h0);
    model_clear();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    model_clear();
    @(posedge clk);
    #1;
    hard_reset();

    // reset then read
    step(1, 3, 5, 0, 0, 1, 0, 0, 16'h0);
    idle();

    // zero register ignores writes and stays unclaimed-clean
    step(0, 0, 0, 0, 0, 1, 1, 0, 16'hFFFF);
    step(1, 0, 0, 0, 0, 1, 0, 0, 16'h0);
    idle();
    chk("zero_err", err_wb_unclaimed, 1'b0);

    // claim then write r3, read it back
    step(1, 0, 0, 3, 1, 1, 0, 0, 16'h0);
    step(0, 0, 0, 0, 0, 1, 1, 3, 16'h1234);
    step(1, 3, 0, 0, 0, 1, 0, 0, 16'h0);
    idle();

    // RAW stall on r4 then bypass
    step(1, 0, 0, 4, 1, 1, 0, 0, 16'h0);
    repeat (3) step(1, 4, 0, 0, 0, 1, 0, 0, 16'h0);
    chk("raw_busy4", busy[4], 1'b1);
    step(1, 4, 0, 0, 0, 1, 1, 4, 16'hBEEF);
    idle();

    // back-pressure: held pair, then no-bubble handoff
    step(1, 3, 4, 0, 0, 0, 0, 0, 16'h0);
    repeat (4) step(1, 4, 3, 0, 0, 0, 0, 0, 16'h0);
    step(1, 4, 3, 0, 0, 1, 0, 0, 16'h0);
    idle();

    // set-wins race on r7
    step(1, 0, 0, 7, 1, 1, 0, 0, 16'h0);
    step(1, 0, 0, 7, 1, 1, 1, 7, 16'h5A5A);
    chk("setwins_busy7", busy[7], 1'b1);
    step(1, 7, 0, 0, 0, 1, 0, 0, 16'h0);
    step(1, 7, 0, 0, 0, 1, 1, 7, 16'h2222);
    idle();

    // unclaimed write-back is sticky but still updates r9
    step(0, 0, 0, 0, 0, 1, 1, 9, 16'h0909);
    repeat (3) idle();
    chk("err_sticky", err_wb_unclaimed, 1'b1);
    step(1, 9, 9, 0, 0, 1, 0, 0, 16'h0);
    idle();

    // reset mid-handshake drops the pair and the claim
    step(1, 9, 0, 2, 1, 0, 0, 0, 16'h0);
    hard_reset();
    step(1, 9, 2, 0, 0, 1, 0, 0, 16'h0);
    idle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
